// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit valid/ready words in, one registered bit per clock out.
// Define PARITY_EN to append an even-parity bit to every word.
`timescale 1ns/1ps
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);
`ifdef PARITY_EN
    localparam int P = WIDTH + 1;
`else
    localparam int P = WIDTH;
`endif
    localparam int CW = $clog2(P + 1);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [P-1:0]  r_shift, w_shift_nxt;
    logic [P-1:0]  r_hold, w_hold_nxt;
    logic          r_hold_full, w_hold_full_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_ser_out, w_ser_out_nxt;
    logic          r_ser_valid, w_ser_valid_nxt;
    logic [WIDTH-1:0] w_ord;
    logic [P-1:0]  w_frame;
    logic          w_accept;
    logic          w_last;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_ord = load_data;
        end else begin : g_lsb
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign w_ord[i] = load_data[WIDTH-1-i];
            end
        end
    endgenerate

    // Frame is stored in transmit order: next bit to send sits at the top.
`ifdef PARITY_EN
    assign w_frame = {w_ord, ^load_data};
`else
    assign w_frame = w_ord;
`endif

    assign load_ready = !r_hold_full;
    assign w_accept   = load_valid && load_ready;
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;
        w_ser_out_nxt   = r_ser_out;
        w_ser_valid_nxt = r_ser_valid;
        case (r_state)
            S_IDLE: begin
                w_ser_out_nxt   = IDLE_LEVEL;
                w_ser_valid_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt     = S_SHIFT;
                    w_ser_out_nxt   = w_frame[P-1];
                    w_shift_nxt     = {w_frame[P-2:0], 1'b0};
                    w_cnt_nxt       = '0;
                    w_ser_valid_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                w_ser_valid_nxt = 1'b1;
                if (!w_last) begin
                    w_ser_out_nxt = r_shift[P-1];
                    w_shift_nxt   = {r_shift[P-2:0], 1'b0};
                    w_cnt_nxt     = r_cnt + 1'b1;
                    if (w_accept) begin
                        w_hold_nxt      = w_frame;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    w_ser_out_nxt   = r_hold[P-1];
                    w_shift_nxt     = {r_hold[P-2:0], 1'b0};
                    w_cnt_nxt       = '0;
                    w_hold_full_nxt = w_accept;
                    if (w_accept) begin
                        w_hold_nxt = w_frame;
                    end
                end else if (w_accept) begin
                    w_ser_out_nxt = w_frame[P-1];
                    w_shift_nxt   = {w_frame[P-2:0], 1'b0};
                    w_cnt_nxt     = '0;
                end else begin
                    w_state_nxt     = S_IDLE;
                    w_ser_out_nxt   = IDLE_LEVEL;
                    w_ser_valid_nxt = 1'b0;
                    w_shift_nxt     = '0;
                    w_cnt_nxt       = '0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_shift_nxt     = '0;
                w_hold_full_nxt = 1'b0;
                w_cnt_nxt       = '0;
                w_ser_out_nxt   = IDLE_LEVEL;
                w_ser_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign busy      = (r_state == S_SHIFT) | r_hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: stimulus pushes hand-computed serial bits into queues;
// per-instance monitors pop and compare on every ser_valid cycle.
`timescale 1ns/1ps
module tb_piso_serializer;
`ifdef PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk    = 1'b0;
    logic       nRESET = 1'b0;
    logic       lv_m   = 1'b0;
    logic       lv_l   = 1'b0;
    logic [7:0] ld_m   = 8'h00;
    logic [7:0] ld_l   = 8'h00;
    logic       rdy_m, so_m, sv_m, bz_m;
    logic       rdy_l, so_l, sv_l, bz_l;

    int n_checks = 0;
    int n_fail   = 0;
    bit q_m[$];
    bit q_l[$];
    int run_m  = 0;
    int last_m = 0;
    int run_l  = 0;
    int last_l = 0;
    bit nr_seen = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .nRESET(nRESET),
        .load_valid(lv_m), .load_data(ld_m), .load_ready(rdy_m),
        .ser_out(so_m), .ser_valid(sv_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .nRESET(nRESET),
        .load_valid(lv_l), .load_data(ld_l), .load_ready(rdy_l),
        .ser_out(so_l), .ser_valid(sv_l), .busy(bz_l)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : mon_m
        bit e;
        forever begin
            @(negedge clk);
            if (!nRESET) begin
                run_m = 0;
            end else begin
                if (!rdy_m) nr_seen = 1'b1;
                if (sv_m) begin
                    run_m++;
                    if (q_m.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL msb_unexpected: ser_valid=1 ser_out=%0b, no bit expected", so_m);
                    end else begin
                        e = q_m.pop_front();
                        check("msb_bit", 32'(so_m), 32'(e));
                    end
                end else begin
                    if (run_m != 0) last_m = run_m;
                    run_m = 0;
                end
            end
        end
    end

    initial begin : mon_l
        bit e;
        forever begin
            @(negedge clk);
            if (!nRESET) begin
                run_l = 0;
            end else if (sv_l) begin
                run_l++;
                if (q_l.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lsb_unexpected: ser_valid=1 ser_out=%0b, no bit expected", so_l);
                end else begin
                    e = q_l.pop_front();
                    check("lsb_bit", 32'(so_l), 32'(e));
                end
            end else begin
                if (run_l != 0) last_l = run_l;
                run_l = 0;
            end
        end
    end

    // exp holds the transmit sequence MSB-down: 8 data bits then parity.
    task automatic offer(input bit lsb, input logic [7:0] d, input logic [8:0] exp);
        int k;
        logic r;
        if (lsb) begin
            lv_l = 1'b1; ld_l = d;
            for (int i = 0; i < NB; i++) q_l.push_back(exp[8-i]);
        end else begin
            lv_m = 1'b1; ld_m = d;
            for (int i = 0; i < NB; i++) q_m.push_back(exp[8-i]);
        end
        k = 0;
        @(negedge clk);
        r = lsb ? rdy_l : rdy_m;
        while (!r && k < 50) begin
            @(negedge clk);
            r = lsb ? rdy_l : rdy_m;
            k++;
        end
        if (!r) begin
            n_checks++;
            n_fail++;
            $display("FAIL offer_timeout: load_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit lsb, input int exp_run, input string name);
        int   k;
        logic sv, bz;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
            sv = lsb ? sv_l : sv_m;
            bz = lsb ? bz_l : bz_m;
        end while ((sv || bz) && k < 200);
        check({name, "_idle"}, 32'(sv | bz), 32'd0);
        check({name, "_run"}, 32'(lsb ? last_l : last_m), 32'(exp_run));
        check({name, "_drained"}, 32'(lsb ? q_l.size() : q_m.size()), 32'd0);
        check({name, "_idle_out"}, 32'(lsb ? so_l : so_m), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_sv", 32'(sv_m), 32'd0);
        check("rst_so", 32'(so_m), 32'd0);
        check("rst_busy", 32'(bz_m), 32'd0);
        check("rst_ready", 32'(rdy_m), 32'd1);
        @(negedge clk);
        #1 nRESET = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_sv", 32'(sv_m), 32'd0);
        check("idle_so", 32'(so_m), 32'd0);
        check("idle_ready", 32'(rdy_m), 32'd1);
        check("idle_busy", 32'(bz_m), 32'd0);
        check("idle_lsb_ready", 32'(rdy_l), 32'd1);
        check("idle_lsb_busy", 32'(bz_l), 32'd0);
        @(posedge clk);
        #1;

        offer(1'b0, 8'hA5, 9'b1010_0101_0);
        lv_m = 1'b0;
        @(negedge clk);
        check("a5_latency", 32'(sv_m), 32'd1);
        check("a5_busy", 32'(bz_m), 32'd1);
        wait_idle(1'b0, NB, "a5");

        @(posedge clk);
        #1;
        offer(1'b0, 8'hF0, 9'b1111_0000_0);
        offer(1'b0, 8'h0F, 9'b0000_1111_0);
        lv_m = 1'b0;
        @(negedge clk);
        check("stream_hold_ready", 32'(rdy_m), 32'd0);
        check("stream_hold_busy", 32'(bz_m), 32'd1);
        wait_idle(1'b0, 2 * NB, "stream");
        check("stream_ready_after", 32'(rdy_m), 32'd1);

        @(posedge clk);
        #1;
        nr_seen = 1'b0;
        offer(1'b0, 8'h3C, 9'b0011_1100_0);
        lv_m = 1'b0;
        repeat (NB - 1) @(posedge clk);
        #1;
        offer(1'b0, 8'hC3, 9'b1100_0011_0);
        lv_m = 1'b0;
        wait_idle(1'b0, 2 * NB, "bypass");
        check("bypass_ready_always", 32'(nr_seen), 32'd0);

        @(posedge clk);
        #1;
        offer(1'b0, 8'hFF, 9'b1111_1111_0);
        lv_m = 1'b0;
        repeat (3) @(negedge clk);
        #1 nRESET = 1'b0;
        #1;
        check("arst_sv", 32'(sv_m), 32'd0);
        check("arst_so", 32'(so_m), 32'd0);
        check("arst_busy", 32'(bz_m), 32'd0);
        check("arst_ready", 32'(rdy_m), 32'd1);
        q_m.delete();
        repeat (2) @(negedge clk);
        #1 nRESET = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_sv", 32'(sv_m), 32'd0);
        check("post_rst_busy", 32'(bz_m), 32'd0);

        @(posedge clk);
        #1;
        offer(1'b1, 8'h07, 9'b1110_0000_1);
        offer(1'b1, 8'h03, 9'b1100_0000_0);
        lv_l = 1'b0;
        wait_idle(1'b1, 2 * NB, "lsb");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
